// File: rtl/barrel_shift_arbiter.sv
// Round-robin arbiter sharing one 7-bit-amount right barrel shifter; two passes extend the range to 0..255.
// Optional performance counters are enabled with the BSA_PERF_CNT_EN macro.
module barrel_shifter_right #(
  parameter int WIDTH = 196
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [6:0]       i_amt,
  output logic [WIDTH-1:0] o_data
);
  logic [WIDTH-1:0] w_stage [0:7];

  assign w_stage[0] = i_data;
  for (genvar s = 0; s < 7; s++) begin : g_stage
    assign w_stage[s+1] = i_amt[s] ? (w_stage[s] >> (32'd1 << s)) : w_stage[s];
  end
  assign o_data = w_stage[7];
endmodule

module barrel_shift_arbiter #(
  parameter int WIDTH = 196,
  parameter int N_REQ = 4,
  parameter int AMT_W = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ*WIDTH-1:0]    i_req_data,
  input  logic [N_REQ*AMT_W-1:0]    i_req_amt,
  output logic [N_REQ-1:0]          o_req_ready,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [WIDTH-1:0]          o_rsp_data,
  output logic [$clog2(N_REQ)-1:0]  o_rsp_id,
`ifdef BSA_PERF_CNT_EN
  output logic [31:0]               o_op_cnt,
  output logic [31:0]               o_stall_cnt,
`endif
  output logic                      o_busy
);
  localparam int ID_W = $clog2(N_REQ);
  localparam logic [AMT_W-1:0] L_WIDTH = AMT_W'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_work;
  logic [AMT_W-1:0] r_amt;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_ptr;

  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_gnt_id;
  logic             w_found;
  logic [6:0]       w_sh_amt;
  logic [6:0]       w_amt_m127;
  logic [WIDTH-1:0] w_sh_out;

  barrel_shifter_right #(.WIDTH(WIDTH)) u_shifter (
    .i_data (r_work),
    .i_amt  (w_sh_amt),
    .o_data (w_sh_out)
  );

  // Round-robin scan starting just after the last granted requester
  always_comb begin
    int v_idx;
    v_idx    = 0;
    w_gnt    = '0;
    w_gnt_id = '0;
    w_found  = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      v_idx = (int'(r_ptr) + i) % N_REQ;
      if (!w_found && i_req_valid[v_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = ID_W'(v_idx);
      end else begin
        w_found  = w_found;
      end
    end
    if ((r_state == ST_IDLE) && w_found) begin
      w_gnt[w_gnt_id] = 1'b1;
    end else begin
      w_gnt = '0;
    end
  end

  assign o_req_ready = w_gnt;
  assign w_amt_m127  = 7'(r_amt - 8'd127);

  always_comb begin
    w_sh_amt = 7'd0;
    case (r_state)
      ST_PASS1: begin
        if (r_amt[7]) begin
          w_sh_amt = 7'd127;
        end else begin
          w_sh_amt = r_amt[6:0];
        end
      end
      ST_PASS2: w_sh_amt = w_amt_m127;
      default:  w_sh_amt = 7'd0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_PASS1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PASS1: begin
        if (r_amt >= L_WIDTH) begin
          w_state_nxt = ST_RESP;
        end else if (r_amt[7]) begin
          w_state_nxt = ST_PASS2;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_PASS2: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (i_rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture on accept, then shift in place; amounts at or beyond WIDTH flush to zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_work <= '0;
      r_amt  <= '0;
      r_id   <= '0;
      r_ptr  <= ID_W'(N_REQ - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_work <= i_req_data[w_gnt_id*WIDTH +: WIDTH];
            r_amt  <= i_req_amt[w_gnt_id*AMT_W +: AMT_W];
            r_id   <= w_gnt_id;
            r_ptr  <= w_gnt_id;
          end
        end
        ST_PASS1: begin
          if (r_amt >= L_WIDTH) begin
            r_work <= '0;
          end else begin
            r_work <= w_sh_out;
          end
        end
        ST_PASS2: r_work <= w_sh_out;
        default:  r_work <= r_work;
      endcase
    end
  end

  assign o_rsp_valid = (r_state == ST_RESP);
  assign o_rsp_data  = r_work;
  assign o_rsp_id    = r_id;
  assign o_busy      = (r_state != ST_IDLE);

`ifdef BSA_PERF_CNT_EN
  logic [31:0] r_op_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op_cnt    <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else if (r_state == ST_RESP) begin
      if (i_rsp_ready) begin
        r_op_cnt <= r_op_cnt + 32'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign o_op_cnt    = r_op_cnt;
  assign o_stall_cnt = r_stall_cnt;
`endif
endmodule
